// File: rtl/mem_resp_pkg.sv
// Shared types for the mem_resp memory responder: response source tag,
// read-pipeline entry and read-latency bounds.
package mem_resp_pkg;

  localparam int MEM_AW_DEF = 16;
  localparam int MEM_DW_DEF = 32;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 8;

  typedef enum logic {
    SRC_ACC  = 1'b0,
    SRC_HOST = 1'b1
  } src_e;

  typedef struct packed {
    logic                  vld;
    src_e                  src;
    logic [MEM_DW_DEF-1:0] data;
  } rsp_t;

endpackage

// File: rtl/mem_resp_if.sv
// Accelerator + host memory bus seen by mem_resp; master = initiators, slave = responder.
interface mem_resp_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  logic          mem_req;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rdata_vld;
  logic [DW-1:0] mem_rdata;

  logic          host_req;
  logic          host_write;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt;
  logic          host_rdata_vld;
  logic [DW-1:0] host_rdata;

  modport master (
    output mem_req, mem_write, mem_addr, mem_wdata,
    input  mem_rdata_vld, mem_rdata,
    output host_req, host_write, host_addr, host_wdata,
    input  host_gnt, host_rdata_vld, host_rdata
  );

  modport slave (
    input  mem_req, mem_write, mem_addr, mem_wdata,
    output mem_rdata_vld, mem_rdata,
    input  host_req, host_write, host_addr, host_wdata,
    output host_gnt, host_rdata_vld, host_rdata
  );
endinterface

// File: rtl/mem_rsp_pipe.sv
// Fixed-depth delay line of read responses; synchronous clear drops everything in flight.
module mem_rsp_pipe
  import mem_resp_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  rsp_t in_i,
  output rsp_t out_o
);

  rsp_t stage_q [RD_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= in_i;
      for (int i = 1; i < RD_LAT; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign out_o = stage_q[RD_LAT-1];

endmodule

// File: rtl/mem_resp.sv
// Single-array memory responder: accelerator port with absolute priority, host port
// for preload/readback, fixed read latency, out-of-range flag and access counters.
module mem_resp
  import mem_resp_pkg::*;
#(
  parameter int MEM_AW = MEM_AW_DEF,
  parameter int MEM_DW = MEM_DW_DEF,
  parameter int DEPTH  = 4096,
  parameter int RD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  mem_resp_if.slave   bus,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt,
  output logic        oor_err
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
    $error("mem_resp: RD_LAT must be within 1..8");
  end
  if (MEM_DW != MEM_DW_DEF) begin : g_bad_dw
    $error("mem_resp: MEM_DW must match the response entry width");
  end

  logic [MEM_DW-1:0] mem_q [DEPTH];

  logic              gnt, acc_go, host_go, go, in_range;
  logic              sel_write;
  logic [MEM_AW-1:0] sel_addr;
  logic [MEM_DW-1:0] sel_wdata;
  logic [31:0]       addr_ext;
  logic [IW-1:0]     idx;
  logic [31:0]       rd_cnt_q, wr_cnt_q;
  logic              oor_q;
  logic [MEM_DW-1:0] acc_hold_q, host_hold_q;
  logic              acc_hit, host_hit;
  rsp_t              pipe_in, pipe_out;

  // Accelerator always wins; a request seen while rst is high is ignored.
  assign gnt       = bus.host_req & ~bus.mem_req;
  assign acc_go    = bus.mem_req & ~rst;
  assign host_go   = gnt & ~rst;
  assign go        = acc_go | host_go;

  assign sel_write = bus.mem_req ? bus.mem_write : bus.host_write;
  assign sel_addr  = bus.mem_req ? bus.mem_addr  : bus.host_addr;
  assign sel_wdata = bus.mem_req ? bus.mem_wdata : bus.host_wdata;
  assign addr_ext  = 32'(sel_addr);
  assign in_range  = addr_ext < 32'(DEPTH);
  assign idx       = sel_addr[IW-1:0];

  always_ff @(posedge clk) begin
    if (go && sel_write && in_range) mem_q[idx] <= sel_wdata;
  end

  always_comb begin
    pipe_in      = '0;
    pipe_in.vld  = go & ~sel_write;
    pipe_in.src  = bus.mem_req ? SRC_ACC : SRC_HOST;
    pipe_in.data = in_range ? mem_q[idx] : '0;
  end

  mem_rsp_pipe #(.RD_LAT(RD_LAT)) u_pipe (
    .clk   (clk),
    .rst   (rst),
    .in_i  (pipe_in),
    .out_o (pipe_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      oor_q    <= 1'b0;
    end else begin
      if (acc_go &&  bus.mem_write) wr_cnt_q <= wr_cnt_q + 32'd1;
      if (acc_go && !bus.mem_write) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (go && !in_range)          oor_q    <= 1'b1;
    end
  end

  // Data outputs show the live response on a strobe and the last one otherwise.
  assign acc_hit  = pipe_out.vld & (pipe_out.src == SRC_ACC);
  assign host_hit = pipe_out.vld & (pipe_out.src == SRC_HOST);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_hold_q  <= '0;
      host_hold_q <= '0;
    end else begin
      if (acc_hit)  acc_hold_q  <= pipe_out.data;
      if (host_hit) host_hold_q <= pipe_out.data;
    end
  end

  assign bus.host_gnt       = gnt;
  assign bus.mem_rdata_vld  = acc_hit;
  assign bus.mem_rdata      = acc_hit ? pipe_out.data : acc_hold_q;
  assign bus.host_rdata_vld = host_hit;
  assign bus.host_rdata     = host_hit ? pipe_out.data : host_hold_q;
  assign rd_cnt             = rd_cnt_q;
  assign wr_cnt             = wr_cnt_q;
  assign oor_err            = oor_q;

endmodule

// File: tb/tb_mem_resp.sv
// Drives three mem_resp instances (RD_LAT 2, 1, 8) with one stimulus stream and
// checks each against a queue-based reference model every cycle.
module tb_mem_resp;
  import mem_resp_pkg::*;

  localparam int AW = 16, DW = 32, DEPTH = 4096, ND = 3;

  function automatic int lat_of(input int k);
    case (k)
      0:       return 2;
      1:       return 1;
      default: return 8;
    endcase
  endfunction

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_req, mem_write, host_req, host_write;
  logic [AW-1:0] mem_addr, host_addr;
  logic [DW-1:0] mem_wdata, host_wdata;

  wire          o_mvld [ND];
  wire          o_hvld [ND];
  wire          o_gnt  [ND];
  wire          o_oor  [ND];
  wire [DW-1:0] o_mdat [ND];
  wire [DW-1:0] o_hdat [ND];
  wire [31:0]   o_rd   [ND];
  wire [31:0]   o_wr   [ND];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    mem_resp_if #(.AW(AW), .DW(DW)) bus ();
    assign bus.mem_req    = mem_req;
    assign bus.mem_write  = mem_write;
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_wdata  = mem_wdata;
    assign bus.host_req   = host_req;
    assign bus.host_write = host_write;
    assign bus.host_addr  = host_addr;
    assign bus.host_wdata = host_wdata;
    assign o_mvld[g] = bus.mem_rdata_vld;
    assign o_mdat[g] = bus.mem_rdata;
    assign o_hvld[g] = bus.host_rdata_vld;
    assign o_hdat[g] = bus.host_rdata;
    assign o_gnt[g]  = bus.host_gnt;

    mem_resp #(.MEM_AW(AW), .MEM_DW(DW), .DEPTH(DEPTH), .RD_LAT(lat_of(g))) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .rd_cnt  (o_rd[g]),
      .wr_cnt  (o_wr[g]),
      .oor_err (o_oor[g])
    );
  end

  // Reference model: word store, counters, and per-instance queues of due responses.
  typedef struct {
    int            due;
    bit            host;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          q [ND][$];
  logic [DW-1:0] mm [int];
  logic [31:0]   m_rd, m_wr;
  bit            m_oor;
  logic [DW-1:0] m_mhold [ND];
  logic [DW-1:0] m_hhold [ND];
  int            cyc = 0;
  int            n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s lat%0d cyc%0d: got %h expected %h", tag, lat_of(k), cyc, obs, exp);
    end
  endtask

  function automatic void accept(input bit host, input bit wr, input logic [AW-1:0] a,
                                 input logic [DW-1:0] wd);
    bit oor = (int'(a) >= DEPTH);
    if (!host) begin
      if (wr) m_wr++;
      else    m_rd++;
    end
    if (oor) m_oor = 1'b1;
    if (wr) begin
      if (!oor) mm[int'(a)] = wd;
    end else begin
      for (int k = 0; k < ND; k++)
        q[k].push_back('{cyc + lat_of(k), host, oor ? '0 : mm[int'(a)]});
    end
  endfunction

  task automatic tick();
    exp_t e;
    bit   ev_m, ev_h;
    #1;
    for (int k = 0; k < ND; k++) chk("host_gnt", k, 32'(o_gnt[k]), 32'(host_req & ~mem_req));
    if (rst) begin
      for (int k = 0; k < ND; k++) begin
        q[k].delete();
        m_mhold[k] = '0;
        m_hhold[k] = '0;
      end
      m_rd = '0; m_wr = '0; m_oor = 1'b0;
    end else if (mem_req) accept(1'b0, mem_write, mem_addr, mem_wdata);
    else if (host_req)    accept(1'b1, host_write, host_addr, host_wdata);
    @(posedge clk);
    cyc++;
    #1;
    for (int k = 0; k < ND; k++) begin
      ev_m = 1'b0; ev_h = 1'b0;
      if (q[k].size() > 0 && q[k][0].due == cyc) begin
        e = q[k].pop_front();
        if (e.host) begin ev_h = 1'b1; m_hhold[k] = e.data; end
        else        begin ev_m = 1'b1; m_mhold[k] = e.data; end
      end
      chk("mem_rdata_vld",  k, 32'(o_mvld[k]), 32'(ev_m));
      chk("host_rdata_vld", k, 32'(o_hvld[k]), 32'(ev_h));
      chk("mem_rdata",      k, o_mdat[k], m_mhold[k]);
      chk("host_rdata",     k, o_hdat[k], m_hhold[k]);
      chk("rd_cnt",         k, o_rd[k], m_rd);
      chk("wr_cnt",         k, o_wr[k], m_wr);
      chk("oor_err",        k, 32'(o_oor[k]), 32'(m_oor));
    end
  endtask

  task automatic idle(input int n);
    mem_req = 1'b0; host_req = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return AW'(DEPTH + $urandom_range(0, 7));
    return AW'($urandom_range(0, 31));
  endfunction

  initial begin
    bit gnt_now;
    rst = 1'b1;
    mem_req = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_wdata = '0;
    host_req = 1'b0; host_write = 1'b0; host_addr = '0; host_wdata = '0;
    tick(); tick();
    rst = 1'b0;
    for (int k = 0; k < ND; k++) begin
      chk("reset_rd_cnt", k, o_rd[k], 32'd0);
      chk("reset_oor",    k, 32'(o_oor[k]), 32'd0);
    end

    // Host preload, then accelerator back-to-back readback
    for (int i = 0; i < 32; i++) begin
      host_req = 1'b1; host_write = 1'b1; host_addr = AW'(i); host_wdata = DW'(i + 'h100);
      tick();
    end
    host_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mem_req = 1'b1; mem_write = 1'b0; mem_addr = AW'(i);
      tick();
    end
    idle(10);
    for (int k = 0; k < ND; k++) begin
      chk("preload_rd_cnt", k, o_rd[k], 32'd16);
      chk("preload_last",   k, o_mdat[k], 32'h10F);
    end

    // Arbitration: host held off for 5 accelerator cycles
    host_req = 1'b1; host_write = 1'b0; host_addr = AW'(3);
    for (int i = 0; i < 5; i++) begin
      mem_req = 1'b1; mem_write = 1'b0; mem_addr = AW'(5 + i);
      tick();
    end
    mem_req = 1'b0;
    tick();
    host_req = 1'b0;
    idle(10);
    for (int k = 0; k < ND; k++) chk("arb_host_data", k, o_hdat[k], 32'h103);

    // Read-after-write on the next cycle
    mem_req = 1'b1; mem_write = 1'b1; mem_addr = AW'(7); mem_wdata = 32'hDEADBEEF;
    tick();
    mem_write = 1'b0;
    tick();
    idle(10);
    for (int k = 0; k < ND; k++) begin
      chk("raw_data",   k, o_mdat[k], 32'hDEADBEEF);
      chk("raw_wr_cnt", k, o_wr[k], 32'd1);
    end

    // Out of range read and write
    mem_req = 1'b1; mem_write = 1'b0; mem_addr = AW'(DEPTH + 3);
    tick();
    mem_write = 1'b1; mem_addr = AW'(DEPTH); mem_wdata = 32'h5555AAAA;
    tick();
    mem_write = 1'b0; mem_addr = AW'(0);
    tick();
    idle(10);
    for (int k = 0; k < ND; k++) begin
      chk("oor_flag",       k, 32'(o_oor[k]), 32'd1);
      chk("oor_no_alias",   k, o_mdat[k], 32'h100);
    end

    // Random mixed traffic; host fields stay stable until granted
    for (int i = 0; i < 200; i++) begin
      mem_req   = ($urandom_range(0, 1) == 1);
      mem_write = ($urandom_range(0, 3) == 0);
      mem_addr  = rand_addr();
      mem_wdata = $urandom;
      if (!host_req && $urandom_range(0, 2) == 0) begin
        host_req   = 1'b1;
        host_write = ($urandom_range(0, 3) == 0);
        host_addr  = rand_addr();
        host_wdata = $urandom;
      end
      gnt_now = host_req & ~mem_req;
      tick();
      if (gnt_now) host_req = 1'b0;
    end
    idle(10);

    // Reset with reads in flight and a request in the reset cycle
    for (int i = 0; i < 3; i++) begin
      mem_req = 1'b1; mem_write = 1'b0; mem_addr = AW'(i + 1);
      tick();
    end
    rst = 1'b1; mem_addr = AW'(9);
    tick();
    rst = 1'b0;
    for (int k = 0; k < ND; k++) chk("rst_rd_cnt", k, o_rd[k], 32'd0);
    idle(10);
    mem_req = 1'b1; mem_write = 1'b0; mem_addr = AW'(12);
    tick();
    idle(10);
    for (int k = 0; k < ND; k++) begin
      chk("post_rst_rd_cnt", k, o_rd[k], 32'd1);
      chk("drained",         k, 32'(q[k].size()), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
